// File: rtl/aes_pkg.sv
// Shared AES definitions for the column-serial MixColumns engine.
// Provides the FSM state type, GF(2^8) reduction constant, byte/column/state
// widths and the xtime / gf_mul helpers used by the single-column mixer.
// Optional build macro used by the clients of this package: INV_MIX_COLUMNS_EN.
package aes_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned COL_W    = 32;
    localparam int unsigned STATE_W  = 128;
    localparam int unsigned NUM_COLS = 4;

    // x^8 + x^4 + x^3 + x + 1 with the x^8 term dropped
    localparam logic [7:0] AES_REDUCE = 8'h1B;

    typedef enum logic [1:0] {
        IDLE,
        MIX,
        DONE
    } mix_state_e;

    // Multiply by x in GF(2^8)
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_REDUCE : 8'h00);
    endfunction

    // Multiply by a small constant (only 4-bit coefficients are ever needed)
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) begin
                acc = acc ^ p;
            end
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for mix_columns_seq.
//   in_valid/in_ready/in_data    : producer side, one 128-bit AES state per handshake
//   out_valid/out_ready/out_data : consumer side, mixed state held until accepted
//   busy                         : engine is mixing or holding a result
//   inv (only with INV_MIX_COLUMNS_EN): 1 selects InvMixColumns, latched with in_data
// Modports: slave = the engine, master = the producer/consumer environment.
interface mix_columns_seq_if;

`ifdef INV_MIX_COLUMNS_EN
    logic         inv;
`endif
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_data;
    logic         busy;

    modport slave (
`ifdef INV_MIX_COLUMNS_EN
        input  inv,
`endif
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output busy
    );

    modport master (
`ifdef INV_MIX_COLUMNS_EN
        output inv,
`endif
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  busy
    );

endinterface

// File: rtl/mix_single_column.sv
// Combinational MixColumns on one 32-bit column {a0,a1,a2,a3} (a0 in bits 0:7).
// Ports:
//   inv     : (INV_MIX_COLUMNS_EN only) 1 = InvMixColumns {0e,0b,0d,09}
//   col_in  : input column, big-endian byte order
//   col_out : mixed column, same ordering
// Without INV_MIX_COLUMNS_EN the block contains only the forward {02,03,01,01} path.
module mix_single_column
    import aes_pkg::*;
(
`ifdef INV_MIX_COLUMNS_EN
    input  logic             inv,
`endif
    input  logic [0:COL_W-1] col_in,
    output logic [0:COL_W-1] col_out
);

    logic [7:0] a [NUM_COLS];
    logic [7:0] b [NUM_COLS];

    always_comb begin
        for (int i = 0; i < NUM_COLS; i++) begin
            a[i] = col_in[BYTE_W*i +: BYTE_W];
        end
        for (int i = 0; i < NUM_COLS; i++) begin
`ifdef INV_MIX_COLUMNS_EN
            if (inv) begin
                b[i] = gf_mul(a[i], 4'he) ^ gf_mul(a[2'(i + 1)], 4'hb)
                     ^ gf_mul(a[2'(i + 2)], 4'hd) ^ gf_mul(a[2'(i + 3)], 4'h9);
            end else
`endif
            begin
                // 3*x = xtime(x) ^ x
                b[i] = xtime(a[i]) ^ xtime(a[2'(i + 1)]) ^ a[2'(i + 1)]
                     ^ a[2'(i + 2)] ^ a[2'(i + 3)];
            end
        end
        for (int i = 0; i < NUM_COLS; i++) begin
            col_out[BYTE_W*i +: BYTE_W] = b[i];
        end
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Column-serial MixColumns engine. Captures one AES state, mixes COLS_PER_CYCLE
// columns per cycle through shared mix_single_column instances, then holds the
// result until the consumer accepts it. No overlap between blocks.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (discards any block in flight)
//   bus : mix_columns_seq_if.slave (in/out valid-ready handshakes, busy, optional inv)
// Parameters:
//   COLS_PER_CYCLE : 1, 2 or 4 columns per cycle; latency = 4 / COLS_PER_CYCLE cycles
// Build option: INV_MIX_COLUMNS_EN adds bus.inv to select InvMixColumns per block.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    mix_columns_seq_if.slave       bus
);

    localparam int unsigned NUM_STEPS = NUM_COLS / COLS_PER_CYCLE;
    localparam int unsigned CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mix_state_e         st;
    logic [CNT_W-1:0]   cnt;
    logic [0:STATE_W-1] state_q;
    logic [0:STATE_W-1] state_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
`ifdef INV_MIX_COLUMNS_EN
    logic               inv_q;
`endif

    logic [0:COL_W-1]   col_in  [COLS_PER_CYCLE];
    logic [0:COL_W-1]   col_out [COLS_PER_CYCLE];
    int                 base_col;

    // Columns handled in this step: cnt*C .. cnt*C+C-1
    always_comb begin
        base_col = int'(cnt) * int'(COLS_PER_CYCLE);
        for (int c = 0; c < int'(COLS_PER_CYCLE); c++) begin
            col_in[c] = state_q[COL_W*(base_col + c) +: COL_W];
        end
    end

    // Kept separate from the column select so the mixer path is not a false loop
    always_comb begin
        state_d = state_q;
        for (int c = 0; c < int'(COLS_PER_CYCLE); c++) begin
            state_d[COL_W*(base_col + c) +: COL_W] = col_out[c];
        end
    end

    for (genvar g = 0; g < int'(COLS_PER_CYCLE); g++) begin : g_mixer
        mix_single_column u_mix (
`ifdef INV_MIX_COLUMNS_EN
            .inv     (inv_q),
`endif
            .col_in  (col_in[g]),
            .col_out (col_out[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= IDLE;
            cnt         <= '0;
            state_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef INV_MIX_COLUMNS_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            unique case (st)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        st         <= MIX;
                        cnt        <= '0;
                        state_q    <= bus.in_data;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef INV_MIX_COLUMNS_EN
                        inv_q      <= bus.inv;
`endif
                    end
                end
                MIX: begin
                    state_q <= state_d;
                    if (cnt == LAST_STEP) begin
                        st          <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        st          <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = state_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: reference model of (Inv)MixColumns,
// per-cycle compare process against a transaction queue, plus directed vectors.
module tb_mix_columns_seq;

    localparam int unsigned STEPS = 4;

    localparam logic [127:0] V1 = 128'h6353e08c0960e104cd70b751bacad0e7;
    localparam logic [127:0] E1 = 128'h5f72641557f5bc92f7be3b291db9f91a;
    localparam logic [127:0] V2 = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] E2 = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] VR = 128'h1f2bc3771f2bc3771f2bc3771f2bc377;
    localparam logic [127:0] ER = 128'hf7603027f7603027f7603027f7603027;
    localparam logic [127:0] V3 = 128'h3bd92268fc74fb735767cbe0c0590e2d;
    localparam logic [127:0] E3 = 128'h4c9c1e66f771f0762c3f868e534df256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mix_columns_seq_if bus ();
    mix_columns_seq_if bus2 ();
    mix_columns_seq_if bus4 ();

    mix_columns_seq #(.COLS_PER_CYCLE(1)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] k);
        logic [7:0] a;
        logic [7:0] p;
        a = a_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] mixcols(input logic [127:0] s, input bit inv);
        logic [127:0] r;
        logic [7:0]   coef [4];
        logic [7:0]   a    [4];
        logic [7:0]   b;
        if (inv) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 8*(4*c + k) -: 8];
            for (int k = 0; k < 4; k++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++) b = b ^ gmul(a[(k + j) % 4], coef[j]);
                r[127 - 8*(4*c + k) -: 8] = b;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- compare process state ----------------
    bit           mon_en = 0;
    bit           m_busy = 0;
    int           m_left = 0;
    logic [127:0] m_q [$];
    int           acc_cyc = 0;
    logic         prev_ov = 1'b0;
    int           rise_q [$];

    int           s2_acc = 0, s4_acc = 0, s2_lat = -1, s4_lat = -1;
    bit           s2_got = 0, s4_got = 0;
    logic [127:0] s2_data, s4_data;

    task automatic monitor();
        bit inv_now;
        if (!mon_en) return;
        // outputs must match the transaction-level model for the cycle just ended
        chk("mon_in_ready", 128'(bus.in_ready), 128'(!m_busy));
        chk("mon_busy", 128'(bus.busy), 128'(m_busy));
        chk("mon_out_valid", 128'(bus.out_valid), 128'(m_busy && m_left == 0));
        if (m_busy && m_left == 0) begin
            if (m_q.size() == 0) chk("mon_queue", 128'(0), 128'(1));
            else chk("mon_out_data", bus.out_data, m_q[0]);
        end
        if (bus.out_valid && !prev_ov) begin
            rise_q.push_back(cyc);
            chk("mon_latency", 128'(cyc - acc_cyc), 128'(STEPS));
        end
        prev_ov = bus.out_valid;

        // advance the model to the state after the coming clock edge
        inv_now = 0;
`ifdef INV_MIX_COLUMNS_EN
        inv_now = bus.inv;
`endif
        if (rst) begin
            m_busy = 0;
            m_left = 0;
            m_q.delete();
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                m_busy  = 1;
                m_left  = STEPS;
                acc_cyc = cyc + 1;
                m_q.push_back(mixcols(bus.in_data, inv_now));
            end
        end else if (m_left > 0) begin
            m_left--;
        end else if (bus.out_ready) begin
            m_busy = 0;
            void'(m_q.pop_front());
        end

        // wider-configuration instances: record latency and first result
        if (!rst && bus2.in_valid && bus2.in_ready) begin s2_acc = cyc + 1; s2_got = 0; end
        if (!rst && bus4.in_valid && bus4.in_ready) begin s4_acc = cyc + 1; s4_got = 0; end
        if (bus2.out_valid && !s2_got) begin s2_got = 1; s2_lat = cyc - s2_acc; s2_data = bus2.out_data; end
        if (bus4.out_valid && !s4_got) begin s4_got = 1; s4_lat = cyc - s4_acc; s4_data = bus4.out_data; end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            cycle();
            n++;
        end
        chk("out_valid_timeout", 128'(bus.out_valid), 128'(1));
    endtask

    task automatic run_block(input logic [127:0] v, output logic [127:0] res, output int lat);
        bus.in_data  = v;
        bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        wait_out(lat);
        res = bus.out_data;
        cycle();
    endtask

    logic [127:0] res;
    logic [127:0] vecs [3];
    logic [127:0] exps [3];
    logic [127:0] got [$];
    int           lat;
    int           idx;
    bit           acc;

    initial begin
        rst = 1'b1;
        bus.in_valid = 0;  bus.out_ready = 1;  bus.in_data = '0;
        bus2.in_valid = 0; bus2.out_ready = 1; bus2.in_data = '0;
        bus4.in_valid = 0; bus4.out_ready = 1; bus4.in_data = '0;
`ifdef INV_MIX_COLUMNS_EN
        bus.inv = 0; bus2.inv = 0; bus4.inv = 0;
`endif
        // model pinned to hand-computed values
        chk("model_v1", mixcols(V1, 0), E1);
        chk("model_v2", mixcols(V2, 0), E2);
        chk("model_rep", mixcols(VR, 0), ER);
        chk("model_v3", mixcols(V3, 0), E3);
        chk("model_inv", mixcols(E1, 1), V1);

        @(posedge clk); #1;
        @(posedge clk); #1;
        mon_en = 1;
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_out_data", bus.out_data, 128'(0));
        cycle();
        rst = 1'b0;
        cycle();

        // 1: single block, latency and in_ready return
        bus.in_data = V1; bus.in_valid = 1;
        cycle();
        bus.in_valid = 0;
        chk("t1_busy", 128'(bus.busy), 128'(1));
        wait_out(lat);
        chk("t1_latency", 128'(lat), 128'(STEPS));
        chk("t1_data", bus.out_data, E1);
        chk("t1_in_ready_low", 128'(bus.in_ready), 128'(0));
        cycle();
        chk("t1_in_ready_back", 128'(bus.in_ready), 128'(1));
        chk("t1_out_valid_low", 128'(bus.out_valid), 128'(0));

        // 2: same vector through 1, 2 and 4 columns per cycle
        bus.in_data = V2; bus2.in_data = V2; bus4.in_data = V2;
        bus.in_valid = 1; bus2.in_valid = 1; bus4.in_valid = 1;
        cycle();
        bus.in_valid = 0; bus2.in_valid = 0; bus4.in_valid = 0;
        wait_out(lat);
        chk("t2_c1_data", bus.out_data, E2);
        chk("t2_c2_got", 128'(s2_got), 128'(1));
        chk("t2_c4_got", 128'(s4_got), 128'(1));
        chk("t2_c2_latency", 128'(s2_lat), 128'(2));
        chk("t2_c4_latency", 128'(s4_lat), 128'(1));
        chk("t2_c2_data", s2_data, E2);
        chk("t2_c4_data", s4_data, E2);
        cycle();
        run_block(VR, res, lat);
        chk("t2_rep_data", res, ER);

        // 3: backpressure with a second request waiting
        bus.out_ready = 0;
        bus.in_data = V3; bus.in_valid = 1;
        cycle();
        bus.in_data = V1;
        wait_out(lat);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t3_hold_valid", 128'(bus.out_valid), 128'(1));
            chk("t3_hold_data", bus.out_data, E3);
            chk("t3_hold_in_ready", 128'(bus.in_ready), 128'(0));
        end
        bus.out_ready = 1;
        cycle();
        chk("t3_after_out_in_ready", 128'(bus.in_ready), 128'(1));
        chk("t3_after_out_busy", 128'(bus.busy), 128'(0));
        cycle();
        bus.in_valid = 0;
        chk("t3_second_taken", 128'(bus.busy), 128'(1));
        wait_out(lat);
        chk("t3_second_data", bus.out_data, E1);
        cycle();

        // 4: reset while mixing
        bus.in_data = V2; bus.in_valid = 1;
        cycle();
        bus.in_valid = 0;
        cycle();
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        chk("t4_in_ready", 128'(bus.in_ready), 128'(1));
        chk("t4_out_valid", 128'(bus.out_valid), 128'(0));
        chk("t4_busy", 128'(bus.busy), 128'(0));
        cycle();
        chk("t4_no_output", 128'(bus.out_valid), 128'(0));
        run_block(V1, res, lat);
        chk("t4_next_data", res, E1);

        // 5: back-to-back with valid and ready held high
        vecs[0] = V1; vecs[1] = V2; vecs[2] = V3;
        exps[0] = E1; exps[1] = E2; exps[2] = E3;
        rise_q.delete();
        got.delete();
        idx = 0;
        bus.in_data = vecs[0]; bus.in_valid = 1;
        for (int n = 0; n < 80 && got.size() < 3; n++) begin
            acc = bus.in_ready && bus.in_valid;
            cycle();
            if (acc) begin
                idx++;
                if (idx < 3) bus.in_data = vecs[idx];
                else bus.in_valid = 0;
            end
            if (bus.out_valid) got.push_back(bus.out_data);
        end
        bus.in_valid = 0;
        chk("t5_count", 128'(got.size()), 128'(3));
        for (int i = 0; i < 3 && i < got.size(); i++) chk("t5_order", got[i], exps[i]);
        cycle();
        chk("t5_rises", 128'(rise_q.size()), 128'(3));
        for (int i = 1; i < rise_q.size(); i++)
            chk("t5_spacing", 128'(rise_q[i] - rise_q[i-1]), 128'(STEPS + 2));

`ifdef INV_MIX_COLUMNS_EN
        // 6: inverse mode latched at accept, inv toggling afterwards ignored
        bus.inv = 1; bus.in_data = E1; bus.in_valid = 1;
        cycle();
        bus.in_valid = 0;
        bus.inv = 0;
        cycle();
        bus.inv = 1;
        cycle();
        bus.inv = 0;
        wait_out(lat);
        chk("t6_inv_data", bus.out_data, V1);
        cycle();
        run_block(V1, res, lat);
        chk("t6_fwd_data", res, E1);
`endif

        cycle();
        cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
